// File: rtl/stl_sort_seq.sv
// -----------------------------------------------------------------------------
// stl_sort_seq
//   Frame-based sorter. Beats (key in_cmp + payload in_sel) are collected
//   into a frame buffer, sorted in one shot by a combinational bitonic
//   network, then replayed in sorted order. MODE=0 emits keys in descending
//   order and MODE=1 in ascending order. Equal keys may come out in any
//   relative order.
//
//   Frame flow: IDLE -> FILL -> SORT -> DRAIN -> IDLE. Input and output never
//   overlap. A frame ends on an accepted in_last, or when DN beats have been
//   accepted without one.
//
// Optional feature (macro STL_SORT_SEQ_OREG_EN):
//   Adds a pipeline register after the sort network. SORT then lasts two
//   cycles instead of one. The output order is the same either way.
//
// Handshake rule (both ports): a beat transfers on a rising clk edge where
//   vld and rdy are both high. The producer holds the beat steady while vld
//   is high and rdy is low. in_rdy is high only in IDLE/FILL. out_vld is high
//   only in DRAIN.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_vld/in_rdy              input beat handshake
//   in_cmp[CW], in_sel[DW]     key and attached data
//   in_last                    last beat of the frame
//   out_vld/out_rdy            output beat handshake
//   out_cmp[CW], out_sel[DW]   sorted key and its data
//   out_last                   final beat of the sorted frame
//   busy                       FSM is not in IDLE
// -----------------------------------------------------------------------------
module stl_sort_seq #(
  parameter int DN   = 16,
  parameter int CW   = 4,
  parameter int DW   = 8,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [CW-1:0] in_cmp,
  input  logic [DW-1:0] in_sel,
  input  logic          in_last,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [CW-1:0] out_cmp,
  output logic [DW-1:0] out_sel,
  output logic          out_last,
  output logic          busy
);

  localparam int LG   = $clog2(DN);
  localparam int NP   = 1 << LG;          // network width: DN rounded up to 2^n
  localparam int CNTW = $clog2(DN + 1);
  localparam int KW   = CW + 1;

  // The key's top bit carries validity. Its polarity is chosen so that pads
  // always land after every real entry, whichever direction the sort runs.
  localparam logic PAD_FLAG = (MODE == 1) ? 1'b1 : 1'b0;
  localparam logic VAL_FLAG = ~PAD_FLAG;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SORT, S_DRAIN} state_e;

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] rd_idx_q;
  logic [CNTW-1:0] rd_idx_inc;
  logic [CW-1:0]   out_cmp_q;
  logic [DW-1:0]   out_sel_q;
  logic            out_last_q;

  logic [CW-1:0]   mem_cmp_q [DN];
  logic [DW-1:0]   mem_sel_q [DN];
  logic [CW-1:0]   buf_cmp_q [DN];
  logic [DW-1:0]   buf_sel_q [DN];

  logic [CW-1:0]   net_cmp [DN];
  logic [DW-1:0]   net_sel [DN];
  logic [CW-1:0]   src_cmp [DN];
  logic [DW-1:0]   src_sel [DN];

  logic            in_fire;
  logic            sort_done;

  assign in_rdy     = (state_q == S_IDLE) || (state_q == S_FILL);
  assign out_vld    = (state_q == S_DRAIN);
  assign busy       = (state_q != S_IDLE);
  assign in_fire    = in_vld && in_rdy;
  assign rd_idx_inc = rd_idx_q + 1'b1;

  assign out_cmp  = out_cmp_q;
  assign out_sel  = out_sel_q;
  assign out_last = out_last_q;

  // ---------------------------------------------------------------------------
  // Bitonic sort network. Slots at or above cnt become pads (cmp=0, sel=0).
  // Each segment of size 2^s is sorted in the direction given by bit s of the
  // index. In the last stage every index has bit LG clear, so the final
  // direction is ascending for MODE=1 and descending for MODE=0.
  // ---------------------------------------------------------------------------
  always_comb begin : bitonic_net
    logic [KW-1:0] wk [NP];
    logic [DW-1:0] ws [NP];
    logic [KW-1:0] tk;
    logic [DW-1:0] ts;
    logic          up;
    tk = '0;
    ts = '0;
    up = 1'b0;
    for (int i = 0; i < NP; i++) begin
      wk[i] = {PAD_FLAG, {CW{1'b0}}};
      ws[i] = '0;
      if (i < DN && i < int'(cnt_q)) begin
        wk[i] = {VAL_FLAG, mem_cmp_q[i]};
        ws[i] = mem_sel_q[i];
      end
    end
    for (int s = 1; s <= LG; s++) begin
      for (int t = s - 1; t >= 0; t--) begin
        for (int i = 0; i < NP; i++) begin
          if ((i & (1 << t)) == 0) begin
            up = ((i & (1 << s)) == 0) ^ (MODE == 0);
            if (up ? (wk[i] > wk[i | (1 << t)]) : (wk[i] < wk[i | (1 << t)])) begin
              tk = wk[i];
              ts = ws[i];
              wk[i] = wk[i | (1 << t)];
              ws[i] = ws[i | (1 << t)];
              wk[i | (1 << t)] = tk;
              ws[i | (1 << t)] = ts;
            end
          end
        end
      end
    end
    for (int i = 0; i < DN; i++) begin
      net_cmp[i] = wk[i][CW-1:0];
      net_sel[i] = ws[i];
    end
  end

`ifdef STL_SORT_SEQ_OREG_EN
  // Registered copy of the network output. The first SORT cycle loads it,
  // and the second SORT cycle moves it into the drain buffer.
  logic [CW-1:0] pipe_cmp_q [DN];
  logic [DW-1:0] pipe_sel_q [DN];
  logic          sort_ph_q;

  always_ff @(posedge clk) begin
    if (state_q == S_SORT) begin
      pipe_cmp_q <= net_cmp;
      pipe_sel_q <= net_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sort_ph_q <= 1'b0;
    end else if (state_q == S_SORT) begin
      sort_ph_q <= ~sort_ph_q;
    end
  end

  always_comb begin
    src_cmp = pipe_cmp_q;
    src_sel = pipe_sel_q;
  end
  assign sort_done = sort_ph_q;
`else
  always_comb begin
    src_cmp = net_cmp;
    src_sel = net_sel;
  end
  assign sort_done = 1'b1;
`endif

  // Frame storage and drain buffer. These hold data only and are not reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_cmp_q[cnt_q] <= in_cmp;
      mem_sel_q[cnt_q] <= in_sel;
    end
    if (state_q == S_SORT && sort_done) begin
      buf_cmp_q <= src_cmp;
      buf_sel_q <= src_sel;
    end
  end

  // Control FSM with registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_idx_q   <= '0;
      out_cmp_q  <= '0;
      out_sel_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_vld) begin
            cnt_q   <= CNTW'(1);
            state_q <= in_last ? S_SORT : S_FILL;
          end
        end
        S_FILL: begin
          if (in_vld) begin
            cnt_q <= cnt_q + 1'b1;
            // A full frame closes even without in_last.
            if (in_last || cnt_q == CNTW'(DN - 1)) state_q <= S_SORT;
          end
        end
        S_SORT: begin
          if (sort_done) begin
            rd_idx_q   <= '0;
            out_cmp_q  <= src_cmp[0];
            out_sel_q  <= src_sel[0];
            out_last_q <= (cnt_q == CNTW'(1));
            state_q    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_rdy) begin
            if (out_last_q) begin
              state_q    <= S_IDLE;
              cnt_q      <= '0;
              rd_idx_q   <= '0;
              out_last_q <= 1'b0;
            end else begin
              rd_idx_q   <= rd_idx_inc;
              out_cmp_q  <= buf_cmp_q[rd_idx_inc];
              out_sel_q  <= buf_sel_q[rd_idx_inc];
              out_last_q <= (rd_idx_inc == cnt_q - 1'b1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stl_sort_seq.sv
// Testbench for stl_sort_seq: a MODE=0 (descending) and a MODE=1 (ascending)
// instance share all inputs, so every frame is checked in both directions.
module tb_stl_sort_seq;
  localparam int DN = 16;
  localparam int CW = 4;
  localparam int DW = 8;
`ifdef STL_SORT_SEQ_OREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_vld = 1'b0;
  logic [CW-1:0] in_cmp = '0;
  logic [DW-1:0] in_sel = '0;
  logic          in_last = 1'b0;
  logic          out_rdy = 1'b0;

  logic          in_rdy0, out_vld0, out_last0, busy0;
  logic [CW-1:0] out_cmp0;
  logic [DW-1:0] out_sel0;
  logic          in_rdy1, out_vld1, out_last1, busy1;
  logic [CW-1:0] out_cmp1;
  logic [DW-1:0] out_sel1;

  stl_sort_seq #(.DN(DN), .CW(CW), .DW(DW), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy0), .in_cmp(in_cmp),
    .in_sel(in_sel), .in_last(in_last), .out_vld(out_vld0), .out_rdy(out_rdy),
    .out_cmp(out_cmp0), .out_sel(out_sel0), .out_last(out_last0), .busy(busy0)
  );

  stl_sort_seq #(.DN(DN), .CW(CW), .DW(DW), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy1), .in_cmp(in_cmp),
    .in_sel(in_sel), .in_last(in_last), .out_vld(out_vld1), .out_rdy(out_rdy),
    .out_cmp(out_cmp1), .out_sel(out_sel1), .out_last(out_last1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  // Frame to send, captured output beats, and timing marks.
  logic [CW-1:0] f_cmp [DN];
  logic [DW-1:0] f_sel [DN];
  logic          f_last [DN];
  logic [CW-1:0] g0_cmp [$];
  logic [CW-1:0] g1_cmp [$];
  logic [DW-1:0] g0_sel [$];
  logic [DW-1:0] g1_sel [$];
  logic          g0_last [$];
  logic          g1_last [$];
  int first_acc, last_acc, first_vld, last_hs;

  // ---------------- driver tasks ----------------
  task automatic send_frame(input int n);
    for (int b = 0; b < n; b++) begin
      int wait_n;
      wait_n  = 0;
      in_vld  = 1'b1;
      in_cmp  = f_cmp[b];
      in_sel  = f_sel[b];
      in_last = f_last[b];
      while (!in_rdy0 && wait_n < 100) begin
        @(negedge clk);
        wait_n++;
      end
      if (!in_rdy0) begin
        checks++;
        errors++;
        $display("FAIL send_timeout beat %0d: in_rdy=%b required 1", b, in_rdy0);
      end
      if (b == 0) first_acc = cyc;
      last_acc = cyc;
      @(negedge clk);
    end
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  // Collects one sorted frame from both DUTs. Optionally stalls out_rdy at
  // random, and optionally keeps in_vld high with a junk beat the whole time.
  task automatic collect(input bit stall, input bit hold);
    bit done0 = 1'b0, done1 = 1'b0, st0 = 1'b0, st1 = 1'b0;
    logic [CW-1:0] pc0 = '0, pc1 = '0;
    logic [DW-1:0] ps0 = '0, ps1 = '0;
    logic pl0 = 1'b0, pl1 = 1'b0;
    int rdy_seen = 0;
    g0_cmp.delete(); g1_cmp.delete(); g0_sel.delete(); g1_sel.delete();
    g0_last.delete(); g1_last.delete();
    first_vld = -1;
    last_hs   = -1;
    for (int k = 0; k < 300 && !(done0 && done1); k++) begin
      if (hold) begin
        in_vld = 1'b1; in_cmp = 4'hF; in_sel = 8'hEE; in_last = 1'b1;
      end
      if (st0) begin
        checks++;
        if (out_vld0 !== 1'b1 || out_cmp0 !== pc0 || out_sel0 !== ps0 || out_last0 !== pl0) begin
          errors++;
          $display("FAIL hold_stable0: got vld=%b cmp=%h sel=%h last=%b required 1/%h/%h/%b",
                   out_vld0, out_cmp0, out_sel0, out_last0, pc0, ps0, pl0);
        end
      end
      if (st1) begin
        checks++;
        if (out_vld1 !== 1'b1 || out_cmp1 !== pc1 || out_sel1 !== ps1 || out_last1 !== pl1) begin
          errors++;
          $display("FAIL hold_stable1: got vld=%b cmp=%h sel=%h last=%b required 1/%h/%h/%b",
                   out_vld1, out_cmp1, out_sel1, out_last1, pc1, ps1, pl1);
        end
      end
      if (out_vld0 && first_vld < 0) first_vld = cyc;
      if (out_vld0 && in_rdy0) rdy_seen++;
      out_rdy = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (!done0 && out_vld0 && out_rdy) begin
        g0_cmp.push_back(out_cmp0); g0_sel.push_back(out_sel0); g0_last.push_back(out_last0);
        if (out_last0) begin done0 = 1'b1; last_hs = cyc; end
      end
      if (!done1 && out_vld1 && out_rdy) begin
        g1_cmp.push_back(out_cmp1); g1_sel.push_back(out_sel1); g1_last.push_back(out_last1);
        if (out_last1) done1 = 1'b1;
      end
      st0 = out_vld0 && !out_rdy; pc0 = out_cmp0; ps0 = out_sel0; pl0 = out_last0;
      st1 = out_vld1 && !out_rdy; pc1 = out_cmp1; ps1 = out_sel1; pl1 = out_last1;
      @(negedge clk);
    end
    if (hold) begin in_vld = 1'b0; in_last = 1'b0; end
    out_rdy = 1'b0;
    checks++;
    if (!(done0 && done1)) begin
      errors++;
      $display("FAIL drain_timeout: done0=%b done1=%b required 1/1", done0, done1);
    end
    checks++;
    if (rdy_seen != 0) begin
      errors++;
      $display("FAIL in_rdy_during_drain: got %0d cycles required 0", rdy_seen);
    end
    checks++;
    if (out_vld0 !== 1'b0 || out_vld1 !== 1'b0 || in_rdy0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL post_frame_idle: vld0=%b vld1=%b in_rdy=%b busy=%b required 0/0/1/0",
               out_vld0, out_vld1, in_rdy0, busy0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_rdy0 !== 1'b1 || in_rdy1 !== 1'b1 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_rdy=%b/%b busy=%b/%b required 1/1 0/0", in_rdy0, in_rdy1, busy0, busy1);
    end
    checks++;
    if (out_vld0 !== 1'b0 || out_vld1 !== 1'b0 || out_last0 !== 1'b0 || out_last1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: vld=%b/%b last=%b/%b required 0", out_vld0, out_vld1, out_last0, out_last1);
    end
    checks++;
    if (out_cmp0 !== '0 || out_cmp1 !== '0 || out_sel0 !== '0 || out_sel1 !== '0) begin
      errors++;
      $display("FAIL reset_data: cmp=%h/%h sel=%h/%h required 0", out_cmp0, out_cmp1, out_sel0, out_sel1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [CW-1:0] c_in [5] = '{3, 9, 1, 9, 0};
    int e0 [5] = '{9, 9, 3, 1, 0};
    int e1 [5] = '{0, 1, 3, 9, 9};
    int s0 [5] = '{-1, -1, 'h10, 'h12, 'h14};
    int s1 [5] = '{'h14, 'h12, 'h10, -1, -1};
    for (int b = 0; b < 5; b++) begin
      f_cmp[b] = c_in[b]; f_sel[b] = 8'(16 + b); f_last[b] = (b == 4);
    end
    send_frame(5);
    collect(1'b0, 1'b0);
    checks++;
    if (first_vld - last_acc != LAT) begin
      errors++;
      $display("FAIL basic_latency: got %0d required %0d", first_vld - last_acc, LAT);
    end
    checks++;
    if (g0_cmp.size() != 5 || g1_cmp.size() != 5) begin
      errors++;
      $display("FAIL basic_count: got %0d/%0d required 5", g0_cmp.size(), g1_cmp.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (int'(g0_cmp[i]) != e0[i] || int'(g1_cmp[i]) != e1[i]) begin
          errors++;
          $display("FAIL basic_cmp[%0d]: got %0d/%0d required %0d/%0d", i, g0_cmp[i], g1_cmp[i], e0[i], e1[i]);
        end
        checks++;
        if ((s0[i] >= 0 && int'(g0_sel[i]) != s0[i]) || (s1[i] >= 0 && int'(g1_sel[i]) != s1[i])) begin
          errors++;
          $display("FAIL basic_sel[%0d]: got %h/%h required %0h/%0h", i, g0_sel[i], g1_sel[i], s0[i], s1[i]);
        end
        checks++;
        if (g0_last[i] !== (i == 4) || g1_last[i] !== (i == 4)) begin
          errors++;
          $display("FAIL basic_last[%0d]: got %b/%b required %b", i, g0_last[i], g1_last[i], i == 4);
        end
      end
      checks++;
      if (!((g0_sel[0] == 8'h11 && g0_sel[1] == 8'h13) || (g0_sel[0] == 8'h13 && g0_sel[1] == 8'h11)) ||
          !((g1_sel[3] == 8'h11 && g1_sel[4] == 8'h13) || (g1_sel[3] == 8'h13 && g1_sel[4] == 8'h11))) begin
        errors++;
        $display("FAIL basic_tie_sel: got %h,%h / %h,%h required {11,13}", g0_sel[0], g0_sel[1], g1_sel[3], g1_sel[4]);
      end
    end
  endtask

  task automatic test_single();
    f_cmp[0] = 4'h0; f_sel[0] = 8'hAA; f_last[0] = 1'b1;
    send_frame(1);
    collect(1'b0, 1'b0);
    checks++;
    if (first_vld - last_acc != LAT) begin
      errors++;
      $display("FAIL single_latency: got %0d required %0d", first_vld - last_acc, LAT);
    end
    checks++;
    if (g0_cmp.size() != 1 || g1_cmp.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d/%0d required 1", g0_cmp.size(), g1_cmp.size());
    end else begin
      checks++;
      if (g0_cmp[0] !== 4'h0 || g1_cmp[0] !== 4'h0 || g0_sel[0] !== 8'hAA || g1_sel[0] !== 8'hAA ||
          g0_last[0] !== 1'b1 || g1_last[0] !== 1'b1) begin
        errors++;
        $display("FAIL single_beat: got %h/%h %h/%h last %b/%b required 0 AA 1",
                 g0_cmp[0], g1_cmp[0], g0_sel[0], g1_sel[0], g0_last[0], g1_last[0]);
      end
    end
  endtask

  task automatic test_full_frame();
    for (int b = 0; b < DN; b++) begin
      f_cmp[b] = 4'(b); f_sel[b] = 8'(8'h30 + b); f_last[b] = 1'b0;
    end
    send_frame(DN);
    checks++;
    if (in_rdy0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL full_enter_sort: in_rdy=%b busy=%b required 0/1", in_rdy0, busy0);
    end
    collect(1'b0, 1'b1);
    checks++;
    if (g0_cmp.size() != DN || g1_cmp.size() != DN) begin
      errors++;
      $display("FAIL full_count: got %0d/%0d required %0d", g0_cmp.size(), g1_cmp.size(), DN);
    end else begin
      for (int i = 0; i < DN; i++) begin
        checks++;
        if (int'(g0_cmp[i]) != 15 - i || int'(g1_cmp[i]) != i ||
            int'(g0_sel[i]) != 'h30 + 15 - i || int'(g1_sel[i]) != 'h30 + i) begin
          errors++;
          $display("FAIL full_beat[%0d]: got %h:%h / %h:%h required %0h / %0h", i,
                   g0_cmp[i], g0_sel[i], g1_cmp[i], g1_sel[i], 15 - i, i);
        end
        checks++;
        if (g0_last[i] !== (i == DN - 1) || g1_last[i] !== (i == DN - 1)) begin
          errors++;
          $display("FAIL full_last[%0d]: got %b/%b required %b", i, g0_last[i], g1_last[i], i == DN - 1);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [CW-1:0] c_in [6] = '{5, 2, 7, 2, 0, 11};
    int e0 [6] = '{11, 7, 5, 2, 2, 0};
    int e1 [6] = '{0, 2, 2, 5, 7, 11};
    int s0 [6] = '{'h55, 'h52, 'h50, -1, -1, 'h54};
    int s1 [6] = '{'h54, -1, -1, 'h50, 'h52, 'h55};
    for (int b = 0; b < 6; b++) begin
      f_cmp[b] = c_in[b]; f_sel[b] = 8'(8'h50 + b); f_last[b] = (b == 5);
    end
    send_frame(6);
    collect(1'b1, 1'b0);
    checks++;
    if (g0_cmp.size() != 6 || g1_cmp.size() != 6) begin
      errors++;
      $display("FAIL stall_count: got %0d/%0d required 6", g0_cmp.size(), g1_cmp.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (int'(g0_cmp[i]) != e0[i] || int'(g1_cmp[i]) != e1[i]) begin
          errors++;
          $display("FAIL stall_cmp[%0d]: got %0d/%0d required %0d/%0d", i, g0_cmp[i], g1_cmp[i], e0[i], e1[i]);
        end
        checks++;
        if ((s0[i] >= 0 && int'(g0_sel[i]) != s0[i]) || (s1[i] >= 0 && int'(g1_sel[i]) != s1[i])) begin
          errors++;
          $display("FAIL stall_sel[%0d]: got %h/%h required %0h/%0h", i, g0_sel[i], g1_sel[i], s0[i], s1[i]);
        end
        checks++;
        if (g0_last[i] !== (i == 5) || g1_last[i] !== (i == 5)) begin
          errors++;
          $display("FAIL stall_last[%0d]: got %b/%b required %b", i, g0_last[i], g1_last[i], i == 5);
        end
      end
    end
  endtask

  task automatic test_rst_mid_drain();
    logic [CW-1:0] c_in [5] = '{7, 1, 4, 2, 6};
    logic [CW-1:0] c0 [2];
    logic [CW-1:0] c1 [2];
    logic [DW-1:0] d0 [2];
    logic [DW-1:0] d1 [2];
    int hs = 0;
    int e0 [3] = '{8, 6, 4};
    int e1 [3] = '{4, 6, 8};
    int s0 [3] = '{'h71, 'h72, 'h70};
    int s1 [3] = '{'h70, 'h72, 'h71};
    for (int b = 0; b < 5; b++) begin
      f_cmp[b] = c_in[b]; f_sel[b] = 8'(8'h60 + b); f_last[b] = (b == 4);
    end
    send_frame(5);
    out_rdy = 1'b1;
    for (int k = 0; k < 20 && hs < 2; k++) begin
      if (out_vld0) begin
        c0[hs] = out_cmp0; d0[hs] = out_sel0; c1[hs] = out_cmp1; d1[hs] = out_sel1;
        hs++;
      end
      @(negedge clk);
    end
    out_rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_vld0 !== 1'b0 || out_vld1 !== 1'b0 || busy0 !== 1'b0 || in_rdy0 !== 1'b1 ||
        out_cmp0 !== '0 || out_sel0 !== '0 || out_last0 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: vld=%b/%b busy=%b in_rdy=%b cmp=%h sel=%h last=%b required 0/0 0 1 0 0 0",
               out_vld0, out_vld1, busy0, in_rdy0, out_cmp0, out_sel0, out_last0);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_vld0 !== 1'b0 || out_vld1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_beats: vld=%b/%b required 0/0", out_vld0, out_vld1);
    end
    checks++;
    if (hs != 2) begin
      errors++;
      $display("FAIL rst_mid_pre_count: got %0d required 2", hs);
    end else begin
      checks++;
      if (c0[0] !== 4'd7 || d0[0] !== 8'h60 || c0[1] !== 4'd6 || d0[1] !== 8'h64 ||
          c1[0] !== 4'd1 || d1[0] !== 8'h61 || c1[1] !== 4'd2 || d1[1] !== 8'h63) begin
        errors++;
        $display("FAIL rst_mid_pre_beats: got %h:%h %h:%h / %h:%h %h:%h required 7:60 6:64 / 1:61 2:63",
                 c0[0], d0[0], c0[1], d0[1], c1[0], d1[0], c1[1], d1[1]);
      end
    end
    f_cmp[0] = 4'd4; f_sel[0] = 8'h70; f_last[0] = 1'b0;
    f_cmp[1] = 4'd8; f_sel[1] = 8'h71; f_last[1] = 1'b0;
    f_cmp[2] = 4'd6; f_sel[2] = 8'h72; f_last[2] = 1'b1;
    send_frame(3);
    collect(1'b0, 1'b0);
    checks++;
    if (g0_cmp.size() != 3 || g1_cmp.size() != 3) begin
      errors++;
      $display("FAIL rst_mid_count: got %0d/%0d required 3", g0_cmp.size(), g1_cmp.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (int'(g0_cmp[i]) != e0[i] || int'(g1_cmp[i]) != e1[i] ||
            int'(g0_sel[i]) != s0[i] || int'(g1_sel[i]) != s1[i]) begin
          errors++;
          $display("FAIL rst_mid_beat[%0d]: got %h:%h / %h:%h required %0h:%0h / %0h:%0h", i,
                   g0_cmp[i], g0_sel[i], g1_cmp[i], g1_sel[i], e0[i], s0[i], e1[i], s1[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int e0 [3] = '{3, 2, 1};
    int e1 [3] = '{1, 2, 3};
    int s0 [3] = '{'h91, 'h92, 'h90};
    int s1 [3] = '{'h90, 'h92, 'h91};
    f_cmp[0] = 4'd1; f_sel[0] = 8'h90; f_last[0] = 1'b0;
    f_cmp[1] = 4'd3; f_sel[1] = 8'h91; f_last[1] = 1'b0;
    f_cmp[2] = 4'd2; f_sel[2] = 8'h92; f_last[2] = 1'b1;
    send_frame(3);
    collect(1'b0, 1'b0);
    checks++;
    if (last_hs - first_acc != 6 + (LAT - 2)) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d required %0d", last_hs - first_acc, 6 + (LAT - 2));
    end
    checks++;
    if (g0_cmp.size() != 3 || g1_cmp.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d/%0d required 3", g0_cmp.size(), g1_cmp.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (int'(g0_cmp[i]) != e0[i] || int'(g1_cmp[i]) != e1[i] ||
            int'(g0_sel[i]) != s0[i] || int'(g1_sel[i]) != s1[i]) begin
          errors++;
          $display("FAIL b2b_beat[%0d]: got %h:%h / %h:%h required %0h:%0h / %0h:%0h", i,
                   g0_cmp[i], g0_sel[i], g1_cmp[i], g1_sel[i], e0[i], s0[i], e1[i], s1[i]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_single();
    test_full_frame();
    test_stall();
    test_rst_mid_drain();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
